// File: rtl/mem_line_xfer_pkg.sv
// Shared types and constants for the main-memory line-transfer engine.
package mem_line_xfer_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned WORDS_PER_LINE   = 4;
  localparam int unsigned LINE_WIDTH       = 128;
  localparam int unsigned LINE_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadReq,
    StReadWait,
    StDone
  } mem_xfer_state_t;

  // Word address of beat k within a line-aligned base.
  function automatic logic [31:0] beat_addr(logic [31:0] base, logic [1:0] k);
    return base | {28'b0, k, 2'b00};
  endfunction

endpackage

// File: rtl/mem_line_xfer_if.sv
// Cache-side request/response and memory-side beat signals of mem_line_xfer.
interface mem_line_xfer_if;
  import mem_line_xfer_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [LINE_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [LINE_WIDTH-1:0] resp_rdata;
  logic                  resp_error;
  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_line_xfer_timer.sv
// Per-beat wait counter; expired_o holds once Limit cycles pass without a clear.
module mem_xfer_timer #(
  parameter int unsigned Limit = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CntW'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_line_xfer.sv
// Serialises 128-bit line refills/write-backs into four 32-bit memory beats.
// Optional per-beat timeout abort is enabled by defining MEM_XFER_TIMEOUT_EN.
module mem_line_xfer
  import mem_line_xfer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic            clk,
  input logic            reset,
  mem_line_xfer_if.slave bus
);

  mem_xfer_state_t       state_q, state_d;
  logic [31:0]           base_q, base_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            beat_q, beat_d;
  logic                  err_q, err_d;
  logic                  beat_adv;
  logic                  timeout;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    line_d   = line_q;
    rdata_d  = rdata_q;
    beat_d   = beat_q;
    err_d    = err_q;
    beat_adv = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          base_d = {bus.req_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          beat_d = '0;
          err_d  = 1'b0;
          if (bus.req_write) begin
            line_d  = bus.req_wdata;
            state_d = StWrite;
          end else begin
            line_d  = '0;
            state_d = StReadReq;
          end
        end
      end
      StWrite: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (bus.mem_gnt) begin
          beat_adv = 1'b1;
          if (beat_q == 2'd3) state_d = StDone;
          else                beat_d  = beat_q + 2'd1;
        end
      end
      StReadReq: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (bus.mem_gnt) begin
          state_d = StReadWait;
        end
      end
      StReadWait: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (bus.mem_rvalid) begin
          line_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata;
          if (beat_q == 2'd3) begin
            state_d = StDone;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = StReadReq;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A refill (complete or aborted) publishes its buffer as DONE is entered.
    if (state_d == StDone && (state_q == StReadReq || state_q == StReadWait)) begin
      rdata_d = line_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.mem_req    = (state_q == StWrite || state_q == StReadReq) && !timeout;
  assign bus.mem_we     = (state_q == StWrite) && !timeout;
  assign bus.mem_addr   = beat_addr(base_q, beat_q);
  assign bus.mem_wdata  = line_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.resp_valid = (state_q == StDone);
  assign bus.resp_error = (state_q == StDone) && err_q;
  assign bus.resp_rdata = rdata_q;

  logic unused_addr;
  assign unused_addr = ^bus.req_addr[LINE_OFFSET_BITS-1:0];

`ifdef MEM_XFER_TIMEOUT_EN
  mem_xfer_timer #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clr_i    ((state_d != state_q) || beat_adv),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, beat_adv};
`endif

endmodule

// File: tb/tb_mem_line_xfer.sv
// Self-checking bench for mem_line_xfer: directed table, hand sequences, random requests.
module tb_mem_line_xfer;
  import mem_line_xfer_pkg::*;

  typedef struct packed {
    logic           hold;
    logic           we;
    logic [31:0]    addr;
    logic [127:0]   line;      // write-back data, or words memory returns on a refill
    logic [3:0][3:0] stall;    // grant-low cycles per beat
    logic [3:0][3:0] dly;      // cycles from grant to rvalid per refill beat (>=1)
    logic [7:0]     exp_done;  // cycle of resp_valid, acceptance = cycle 0
    logic [127:0]   exp_rdata;
  } vec_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        wt;
    logic        rvalid;
    logic [31:0] rdata;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [127:0] held = '0;

  mem_line_xfer_if bus ();

  mem_line_xfer #(
    .DATA_WIDTH    (32),
    .LINE_WIDTH    (128),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] model_done(input vec_t v);
    int unsigned t = 1;
    for (int k = 0; k < 4; k++) begin
      t += int'(v.stall[k]) + 1;
      if (!v.we) t += int'(v.dly[k]);
    end
    return 8'(t);
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic apply(input vec_t v);
    step_t tl[$];
    step_t st;
    logic [31:0] base;
    bit done;
    base = {v.addr[31:4], 4'b0};
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s <= int'(v.stall[k]); s++) begin
        st = '0;
        st.req = 1'b1; st.we = v.we; st.addr = base + 32'(4 * k);
        st.wdata = v.line[32*k +: 32]; st.gnt = (s == int'(v.stall[k]));
        tl.push_back(st);
      end
      if (!v.we) begin
        for (int d = 1; d <= int'(v.dly[k]); d++) begin
          st = '0;
          st.wt = 1'b1; st.rvalid = (d == int'(v.dly[k])); st.rdata = v.line[32*k +: 32];
          tl.push_back(st);
        end
      end
    end
    chk("accept_idle", {bus.req_ready, bus.resp_valid, bus.mem_req}, 3'b100);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.we;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.we ? v.line : {$urandom, $urandom, $urandom, $urandom};
    bus.mem_gnt    = 1'($urandom);
    bus.mem_rvalid = 1'($urandom);
    bus.mem_rdata  = $urandom;
    cyc();
    for (int c = 1; c <= int'(v.exp_done); c++) begin
      st   = (c - 1 < tl.size()) ? tl[c-1] : '0;
      done = (c == int'(v.exp_done));
      if (st.req)
        chk("beat", {bus.mem_req, bus.mem_we, bus.mem_addr, st.we ? bus.mem_wdata : 32'h0},
            {1'b1, st.we, st.addr, st.we ? st.wdata : 32'h0});
      else
        chk("mem_req_low", bus.mem_req, 1'b0);
      if (done && !v.we) held = v.exp_rdata;
      chk("resp", {bus.req_ready, bus.resp_valid, bus.resp_error, bus.resp_rdata},
          {1'b0, done, 1'b0, held});
      bus.req_valid  = v.hold;
      bus.req_write  = 1'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = {$urandom, $urandom, $urandom, $urandom};
      bus.mem_gnt    = st.req ? st.gnt : 1'($urandom);
      bus.mem_rvalid = st.wt ? st.rvalid : 1'($urandom);
      bus.mem_rdata  = st.rvalid ? st.rdata : $urandom;
      cyc();
    end
  endtask

  vec_t tab[5];
  vec_t v;

  initial begin
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    tab[0] = '{hold: 1'b0, we: 1'b1, addr: 32'h0000_3A5C,
               line: 128'h44444444_33333333_22222222_11111111,
               stall: '0, dly: '0, exp_done: 8'd5, exp_rdata: '0};
    tab[1] = '{hold: 1'b0, we: 1'b0, addr: 32'h0000_1230,
               line: 128'h000000A3_000000A2_000000A1_000000A0,
               stall: '0, dly: {4'd1, 4'd1, 4'd1, 4'd1}, exp_done: 8'd9,
               exp_rdata: 128'h000000A3_000000A2_000000A1_000000A0};
    tab[2] = '{hold: 1'b0, we: 1'b0, addr: 32'h0000_2008,
               line: 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0,
               stall: {4'd0, 4'd3, 4'd0, 4'd0}, dly: {4'd1, 4'd1, 4'd1, 4'd1}, exp_done: 8'd12,
               exp_rdata: 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0};
    tab[3] = '{hold: 1'b1, we: 1'b1, addr: 32'hFFFF_FFF0,
               line: 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
               stall: '0, dly: '0, exp_done: 8'd5, exp_rdata: '0};
    tab[4] = '{hold: 1'b0, we: 1'b0, addr: 32'h8000_0044,
               line: 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA,
               stall: '0, dly: {4'd2, 4'd1, 4'd3, 4'd1}, exp_done: 8'd12,
               exp_rdata: 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA};

    @(negedge clk);
    chk("reset_vals", {bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_req, bus.mem_we,
                       bus.mem_addr, bus.mem_wdata, bus.resp_rdata}, {1'b1, 196'h0});
    cyc();
    reset = 1'b1;
    cyc();
    chk("post_reset", {bus.req_ready, bus.resp_valid, bus.mem_req, bus.mem_addr, bus.resp_rdata},
        {1'b1, 162'h0});

    for (int i = 0; i < 5; i++) apply(tab[i]);
    bus.req_valid = 1'b0;
    cyc();

    // Reset in READ_WAIT of beat 1 discards the partial line and the held response.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_7770;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    cyc();
    bus.req_valid = 1'b0;
    bus.mem_gnt = 1'b1; cyc();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222; cyc();
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0; cyc();
    chk("rw_beat1_pre", {bus.mem_req, bus.resp_rdata}, {1'b0, held});
    reset = 1'b0;
    #1;
    chk("rst_immediate", {bus.mem_req, bus.resp_valid, bus.resp_rdata}, 130'h0);
    held = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_resp", {bus.resp_valid, bus.req_ready, bus.resp_rdata}, {1'b0, 1'b1, 128'h0});
      cyc();
    end
    bus.mem_rvalid = 1'b0;
    apply(tab[2]);

`ifdef MEM_XFER_TIMEOUT_EN
    // Grant never arrives: 8 wait cycles in READ_REQ, abort to DONE with zeroed line.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0040;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    cyc();
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) held = '0;
      chk("timeout", {bus.mem_req, bus.resp_valid, bus.resp_error, bus.resp_rdata},
          {(c <= 8), (c == 10), (c == 10), held});
      cyc();
    end
`endif

    for (int i = 0; i < 24; i++) begin
      v.hold = 1'($urandom);
      v.we   = 1'($urandom);
      v.addr = $urandom;
      v.line = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
        v.stall[k] = 4'($urandom_range(0, 3));
        v.dly[k]   = 4'($urandom_range(1, 3));
      end
      v.exp_done  = model_done(v);
      v.exp_rdata = v.line;
      apply(v);
    end
    bus.req_valid = 1'b0;
    cyc();
    chk("final_idle", {bus.req_ready, bus.resp_valid, bus.mem_req}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
